sfp_tx_mode_ctrl: RTL and testbench

Controller for the SFP transmit test line on the ZCU102 board. It synchronizes and debounces the eight GPIO DIP switches, mirrors the debounced vector to the LEDs, and uses the switches to select and sequence one of four bit-level test patterns on `sfp_tx`. It sits between the board GPIO pins and the SFP TX input, replacing a direct switch-to-pin connection with a clean, rate-controlled pattern source.

---
 rtl/sfp_tx_pkg.sv | 21 ++
 rtl/sfp_tx_mode_ctrl_switch_debounce.sv | 37 +++
 rtl/sfp_tx_mode_ctrl.sv | 136 +++++++++++++
 tb/tb_sfp_tx_mode_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sfp_tx_pkg.sv
// Shared types and constants for the SFP transmit test-pattern controller.
package sfp_tx_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_CLOCK  = 2'b01,
        MODE_PRBS7  = 2'b10,
        MODE_BYTE   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        BS_START = 2'b00,
        BS_DATA  = 2'b01,
        BS_STOP  = 2'b10,
        BS_IDLE  = 2'b11
    } byte_state_t;

    localparam logic [6:0]  PRBS7_SEED = 7'h7F;
    localparam int unsigned FRAME_LEN  = 11;

endpackage

// File: rtl/sfp_tx_mode_ctrl_switch_debounce.sv
// One switch bit: 2-FF synchronizer followed by a stable-count debouncer.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfp_tx_mode_ctrl.sv
// Debounced DIP switches select and pace one of four test patterns on sfp_tx.
module sfp_tx_mode_ctrl
    import sfp_tx_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BASE_DIV        = 100,
    parameter logic [7:0]  BYTE_PATTERN    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dip_sw,
    output logic [7:0] led_out,
    output logic       sfp_tx,
    output logic [1:0] mode,
    output logic       tx_active
);

    localparam int unsigned CW = $clog2(BASE_DIV * 8);

    logic [7:0]    sw;
    logic [4:0]    sw_prev;
    logic          restart;
    mode_t         cur_mode;

    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] term_cnt;
    logic          tick;

    logic          clk_bit, clk_bit_nxt;
    logic [6:0]    lfsr, lfsr_nxt;
    byte_state_t   byte_state, byte_state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic          tx_nxt;

    for (genvar i = 0; i < 8; i++) begin : g_db
        switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (dip_sw[i]),
            .dout  (sw[i])
        );
    end

    assign led_out   = sw;
    assign mode      = sw[7:6];
    assign cur_mode  = mode_t'(sw[7:6]);
    assign tx_active = (cur_mode != MODE_STATIC);

    // Only mode and rate changes restart; sw[2:0] just feeds STATIC and LEDs.
    assign restart  = (sw[7:3] != sw_prev);
    assign term_cnt = CW'(BASE_DIV * (32'(sw[5:3]) + 32'd1) - 32'd1);
    assign tick     = (tick_cnt == term_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_prev  <= '0;
            tick_cnt <= '0;
        end else begin
            sw_prev  <= sw[7:3];
            tick_cnt <= (restart || tick) ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_bit    <= 1'b0;
            lfsr       <= PRBS7_SEED;
            byte_state <= BS_START;
            idx        <= '0;
            sfp_tx     <= 1'b0;
        end else begin
            clk_bit    <= clk_bit_nxt;
            lfsr       <= lfsr_nxt;
            byte_state <= byte_state_nxt;
            idx        <= idx_nxt;
            sfp_tx     <= tx_nxt;
        end
    end

    // The output bit is taken from the next generator state so a restart
    // shows the new mode's first bit one cycle after the switch change.
    always_comb begin
        clk_bit_nxt    = clk_bit;
        lfsr_nxt       = lfsr;
        byte_state_nxt = byte_state;
        idx_nxt        = idx;
        tx_nxt         = 1'b0;

        if (restart) begin
            clk_bit_nxt    = 1'b0;
            lfsr_nxt       = PRBS7_SEED;
            byte_state_nxt = BS_START;
            idx_nxt        = '0;
        end else begin
            if (lfsr == '0) begin
                lfsr_nxt = PRBS7_SEED;
            end else if (tick) begin
                lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            end
            if (tick) begin
                clk_bit_nxt = ~clk_bit;
                case (byte_state)
                    BS_START: begin
                        byte_state_nxt = BS_DATA;
                        idx_nxt        = '0;
                    end
                    BS_DATA: begin
                        if (idx == 4'd7) begin
                            byte_state_nxt = BS_STOP;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    BS_STOP: byte_state_nxt = BS_IDLE;
                    BS_IDLE: byte_state_nxt = BS_START;
                    default: byte_state_nxt = BS_START;
                endcase
            end
        end

        case (cur_mode)
            MODE_STATIC: tx_nxt = sw[0];
            MODE_CLOCK:  tx_nxt = clk_bit_nxt;
            MODE_PRBS7:  tx_nxt = lfsr_nxt[6];
            MODE_BYTE: begin
                case (byte_state_nxt)
                    BS_START: tx_nxt = 1'b0;
                    BS_DATA:  tx_nxt = BYTE_PATTERN[idx_nxt[2:0]];
                    default:  tx_nxt = 1'b1;
                endcase
            end
            default: tx_nxt = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sfp_tx_mode_ctrl.sv
// Directed self-checking bench for sfp_tx_mode_ctrl (DEBOUNCE_CYCLES=8, BASE_DIV=4).
module tb_sfp_tx_mode_ctrl;
    import sfp_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dip_sw;
    logic [7:0] led_out;
    logic       sfp_tx;
    logic [1:0] mode;
    logic       tx_active;

    int errors = 0;
    int checks = 0;

    sfp_tx_mode_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .BASE_DIV        (4),
        .BYTE_PATTERN    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dip_sw    (dip_sw),
        .led_out   (led_out),
        .sfp_tx    (sfp_tx),
        .mode      (mode),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the cycle where sfp_tx holds the first bit after the change.
    task automatic set_sw(input logic [7:0] v);
        dip_sw = v;
        step(11);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        dip_sw = 8'hFF;
        step(3);
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led_out); end
        checks++; if (sfp_tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b expected 0", sfp_tx); end
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", mode); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", tx_active); end
        rst_n = 1'b1;
        step(9);
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led_early: got %h expected 00", led_out); end
        step(1);
        checks++; if (led_out !== 8'hFF) begin errors++; $display("FAIL reset_led_latency: got %h expected ff", led_out); end
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL reset_mode_after: got %b expected 11", mode); end
        checks++; if (tx_active !== 1'b1) begin errors++; $display("FAIL reset_active_after: got %b expected 1", tx_active); end
    endtask

    task automatic test_debounce();
        dip_sw = 8'h00;
        step(14);
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL deb_clear: got %h expected 00", led_out); end
        dip_sw = 8'h01;
        step(5);
        dip_sw = 8'h00;
        for (int c = 0; c < 16; c++) begin
            checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL deb_glitch_led c=%0d: got %h expected 00", c, led_out); end
            checks++; if (sfp_tx !== 1'b0) begin errors++; $display("FAIL deb_glitch_tx c=%0d: got %b expected 0", c, sfp_tx); end
            step(1);
        end
        dip_sw = 8'h01;
        step(8);
        dip_sw = 8'h00;
        step(1);
        checks++; if (led_out[0] !== 1'b0) begin errors++; $display("FAIL deb_early: got %b expected 0", led_out[0]); end
        step(1);
        checks++; if (led_out[0] !== 1'b1) begin errors++; $display("FAIL deb_accept: got %b expected 1", led_out[0]); end
        checks++; if (sfp_tx !== 1'b0) begin errors++; $display("FAIL deb_tx_early: got %b expected 0", sfp_tx); end
        step(1);
        checks++; if (sfp_tx !== 1'b1) begin errors++; $display("FAIL deb_static_tx: got %b expected 1", sfp_tx); end
        step(14);
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL deb_release: got %h expected 00", led_out); end
    endtask

    task automatic test_clock();
        set_sw(8'h40);
        checks++; if (mode !== 2'b01 || tx_active !== 1'b1) begin errors++; $display("FAIL clk_mode: got %b/%b expected 01/1", mode, tx_active); end
        for (int b = 0; b < 6; b++)
            for (int c = 0; c < 4; c++) begin
                checks++; if (sfp_tx !== b[0]) begin errors++; $display("FAIL clk_r0 b=%0d c=%0d: got %b expected %b", b, c, sfp_tx, b[0]); end
                step(1);
            end
        // Changing sw[1] must not disturb the running pattern.
        dip_sw = 8'h42;
        for (int c = 0; c < 24; c++) begin
            logic e;
            e = ((c / 4) % 2) == 1;
            checks++; if (sfp_tx !== e) begin errors++; $display("FAIL clk_norestart c=%0d: got %b expected %b", c, sfp_tx, e); end
            step(1);
        end
        checks++; if (led_out !== 8'h42) begin errors++; $display("FAIL clk_led: got %h expected 42", led_out); end
        set_sw(8'h4A);
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < 8; c++) begin
                checks++; if (sfp_tx !== b[0]) begin errors++; $display("FAIL clk_r1 b=%0d c=%0d: got %b expected %b", b, c, sfp_tx, b[0]); end
                step(1);
            end
    endtask

    task automatic test_prbs();
        logic [6:0] m;
        logic [7:0] first8;
        m      = 7'h7F;
        first8 = 8'b0111_1111;
        set_sw(8'h80);
        for (int b = 0; b < 135; b++) begin
            logic e;
            e = (b < 8) ? first8[b] : m[6];
            for (int c = 0; c < 4; c++) begin
                checks++; if (sfp_tx !== e) begin errors++; $display("FAIL prbs b=%0d c=%0d: got %b expected %b", b, c, sfp_tx, e); end
                step(1);
            end
            m = {m[5:0], m[6] ^ m[5]};
        end
    endtask

    task automatic test_byte();
        logic [10:0] fr;
        fr = 11'b111_0100_1010;
        set_sw(8'hC0);
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL byte_mode: got %b expected 11", mode); end
        for (int b = 0; b < 25; b++)
            for (int c = 0; c < 4; c++) begin
                checks++; if (sfp_tx !== fr[b % FRAME_LEN]) begin errors++; $display("FAIL byte b=%0d c=%0d: got %b expected %b", b, c, sfp_tx, fr[b % FRAME_LEN]); end
                step(1);
            end
    endtask

    task automatic test_mid_events();
        set_sw(8'h40);
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) begin
                checks++; if (sfp_tx !== b[0]) begin errors++; $display("FAIL mid_clk b=%0d c=%0d: got %b expected %b", b, c, sfp_tx, b[0]); end
                step(1);
            end
        set_sw(8'hC0);
        step(4);
        checks++; if (sfp_tx !== 1'b1) begin errors++; $display("FAIL mid_byte_bit1: got %b expected 1", sfp_tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (sfp_tx !== 1'b0) begin errors++; $display("FAIL mid_rst_tx: got %b expected 0", sfp_tx); end
        checks++; if (led_out !== 8'h00) begin errors++; $display("FAIL mid_rst_led: got %h expected 00", led_out); end
        checks++; if (mode !== 2'b00 || tx_active !== 1'b0) begin errors++; $display("FAIL mid_rst_mode: got %b/%b expected 00/0", mode, tx_active); end
        step(2);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (mode !== 2'b00 || sfp_tx !== 1'b0) begin errors++; $display("FAIL mid_resume c=%0d: got %b/%b expected 00/0", c, mode, sfp_tx); end
            step(1);
        end
        checks++; if (mode !== 2'b11) begin errors++; $display("FAIL mid_remode: got %b expected 11", mode); end
        step(1);
        checks++; if (sfp_tx !== 1'b0) begin errors++; $display("FAIL mid_start_bit: got %b expected 0", sfp_tx); end
        step(4);
        checks++; if (sfp_tx !== 1'b1) begin errors++; $display("FAIL mid_data0: got %b expected 1", sfp_tx); end
    endtask

    initial begin
        rst_n  = 1'b0;
        dip_sw = 8'h00;
        test_reset();
        test_debounce();
        test_clock();
        test_prbs();
        test_byte();
        test_mid_events();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
